// File: rtl/coin_collector_if.sv
// Bundle of coin, selection, core-handshake and refund signals between the
// customer front panel / vending core and the coin_collector stage.
interface coin_collector_if;
  logic       coin5_pulse;
  logic       coin1_pulse;
  logic [1:0] item_sel;
  logic       item_sel_valid;
  logic       cancel;
  logic [1:0] service_type;
  logic [1:0] coinInNTD_5;
  logic [1:0] coinInNTD_1;
  logic [1:0] itemTypeIn;
  logic [4:0] credit_value;
  logic       reject_coin;
  logic       refund_valid;
  logic [1:0] refund5;
  logic [1:0] refund1;
  logic       busy;
  logic       done;

  modport master (
    output coin5_pulse, coin1_pulse, item_sel, item_sel_valid, cancel, service_type,
    input  coinInNTD_5, coinInNTD_1, itemTypeIn, credit_value, reject_coin,
           refund_valid, refund5, refund1, busy, done
  );

  modport slave (
    input  coin5_pulse, coin1_pulse, item_sel, item_sel_valid, cancel, service_type,
    output coinInNTD_5, coinInNTD_1, itemTypeIn, credit_value, reject_coin,
           refund_valid, refund5, refund1, busy, done
  );
endinterface

// File: rtl/coin_collector.sv
// Coin/selection front end: batches coins and an item choice into one request
// for the vending core, refunding on cancel or inactivity.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | no customer; first coin opens a session
//   COLLECT    | accepting coins (max 3 each), waiting for item/cancel
//   REQUEST    | request presented to core until it reports SERVICE_ON
//   WAIT_DONE  | core serving; new customers held off until SERVICE_OFF
module coin_collector #(
  parameter int TIMEOUT_CYCLES = 200,
  parameter int TMR_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  coin_collector_if.slave  bus
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_COLLECT   = 2'd1;
  localparam logic [1:0] ST_REQUEST   = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam logic [1:0] SVC_OFF   = 2'b00;
  localparam logic [1:0] SVC_ON    = 2'b01;
  localparam logic [1:0] ITEM_NONE = 2'b00;
  localparam logic [1:0] CNT_MAX   = 2'd3;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       cnt5_q, cnt5_d;
  logic [1:0]       cnt1_q, cnt1_d;
  logic [1:0]       item_q, item_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       out5_q, out5_d;
  logic [1:0]       out1_q, out1_d;
  logic [1:0]       out_item_q, out_item_d;
  logic             reject_q, reject_d;
  logic             refund_valid_q, refund_valid_d;
  logic [1:0]       refund5_q, refund5_d;
  logic [1:0]       refund1_q, refund1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       coin_any;
  logic       acc5, acc1, acc_any;
  logic       rej_full;
  logic [1:0] sum5, sum1;
  logic       timeout;

  // A coin is accepted only while its count has headroom; the saturated one bounces.
  always_comb begin
    coin_any = bus.coin5_pulse | bus.coin1_pulse;
    acc5     = bus.coin5_pulse & (cnt5_q != CNT_MAX);
    acc1     = bus.coin1_pulse & (cnt1_q != CNT_MAX);
    acc_any  = acc5 | acc1;
    rej_full = (bus.coin5_pulse & ~acc5) | (bus.coin1_pulse & ~acc1);
    sum5     = cnt5_q + {1'b0, acc5};
    sum1     = cnt1_q + {1'b0, acc1};
    timeout  = (tmr_q == TMR_LAST) & ~acc_any;
  end

  always_comb begin
    state_d        = state_q;
    cnt5_d         = cnt5_q;
    cnt1_d         = cnt1_q;
    item_d         = item_q;
    tmr_d          = '0;
    reject_d       = 1'b0;
    refund_valid_d = 1'b0;
    refund5_d      = 2'd0;
    refund1_d      = 2'd0;
    done_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (coin_any) begin
          cnt5_d  = {1'b0, bus.coin5_pulse};
          cnt1_d  = {1'b0, bus.coin1_pulse};
          state_d = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        cnt5_d   = sum5;
        cnt1_d   = sum1;
        reject_d = rej_full;
        tmr_d    = acc_any ? '0 : tmr_q + TMR_W'(1);
        if (bus.cancel || timeout) begin
          // Refund reports the coins accepted on this very cycle too.
          refund_valid_d = 1'b1;
          refund5_d      = sum5;
          refund1_d      = sum1;
          cnt5_d         = 2'd0;
          cnt1_d         = 2'd0;
          tmr_d          = '0;
          state_d        = ST_IDLE;
        end else if (bus.item_sel_valid && (bus.item_sel != ITEM_NONE)) begin
          item_d  = bus.item_sel;
          tmr_d   = '0;
          state_d = ST_REQUEST;
        end
      end

      ST_REQUEST: begin
        reject_d = coin_any;
        if (bus.service_type == SVC_ON) begin
          cnt5_d  = 2'd0;
          cnt1_d  = 2'd0;
          item_d  = ITEM_NONE;
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        reject_d = coin_any;
        if (bus.service_type == SVC_OFF) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Core-facing outputs are registered and only carry data while in REQUEST.
  always_comb begin
    out5_d     = 2'd0;
    out1_d     = 2'd0;
    out_item_d = ITEM_NONE;
    if (state_d == ST_REQUEST) begin
      out5_d     = cnt5_d;
      out1_d     = cnt1_d;
      out_item_d = item_d;
    end
    busy_d = (state_d == ST_REQUEST) || (state_d == ST_WAIT_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt5_q         <= 2'd0;
      cnt1_q         <= 2'd0;
      item_q         <= ITEM_NONE;
      tmr_q          <= '0;
      out5_q         <= 2'd0;
      out1_q         <= 2'd0;
      out_item_q     <= ITEM_NONE;
      reject_q       <= 1'b0;
      refund_valid_q <= 1'b0;
      refund5_q      <= 2'd0;
      refund1_q      <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt5_q         <= cnt5_d;
      cnt1_q         <= cnt1_d;
      item_q         <= item_d;
      tmr_q          <= tmr_d;
      out5_q         <= out5_d;
      out1_q         <= out1_d;
      out_item_q     <= out_item_d;
      reject_q       <= reject_d;
      refund_valid_q <= refund_valid_d;
      refund5_q      <= refund5_d;
      refund1_q      <= refund1_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.coinInNTD_5  = out5_q;
  assign bus.coinInNTD_1  = out1_q;
  assign bus.itemTypeIn   = out_item_q;
  assign bus.credit_value = ({3'b000, cnt5_q} * 5'd5) + {3'b000, cnt1_q};
  assign bus.reject_coin  = reject_q;
  assign bus.refund_valid = refund_valid_q;
  assign bus.refund5      = refund5_q;
  assign bus.refund1      = refund1_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_coin_collector.sv
// Scoreboard bench for coin_collector: directed scenarios then randomized traffic,
// each cycle's expected outputs come from a session-level model of the rules.
module tb_coin_collector;

  localparam int TO = 12;

  logic clk;
  logic reset;
  coin_collector_if bus_if();

  coin_collector #(.TIMEOUT_CYCLES(TO), .TMR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0] o5;
    logic [1:0] o1;
    logic [1:0] oit;
    logic [4:0] credit;
    logic       rej;
    logic       rv;
    logic [1:0] r5;
    logic [1:0] r1;
    logic       busy;
    logic       done;
  } snap_t;

  typedef enum int {P_IDLE, P_COLLECT, P_OFFER, P_WAIT} phase_t;

  snap_t  sb_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc_no   = 0;

  // Customer-session model: coin tallies, chosen item, cycles since last accepted coin.
  phase_t m_phase = P_IDLE;
  int     m_n5 = 0, m_n1 = 0, m_item = 0, m_quiet = 0;

  task automatic cyc(input bit c5, input bit c1, input logic [1:0] sel, input bit selv,
                     input bit cn, input logic [1:0] st, input bit rst);
    snap_t e;
    bit    a5, a1;
    @(negedge clk);
    reset                 = rst;
    bus_if.coin5_pulse    = c5;
    bus_if.coin1_pulse    = c1;
    bus_if.item_sel       = sel;
    bus_if.item_sel_valid = selv;
    bus_if.cancel         = cn;
    bus_if.service_type   = st;
    e = '0;
    if (!rst) begin
      m_phase = P_IDLE; m_n5 = 0; m_n1 = 0; m_item = 0; m_quiet = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (c5 || c1) begin
          m_n5 = int'(c5); m_n1 = int'(c1); m_quiet = 0; m_phase = P_COLLECT;
        end
        P_COLLECT: begin
          a5 = c5 && (m_n5 < 3);
          a1 = c1 && (m_n1 < 3);
          e.rej = (c5 && !a5) || (c1 && !a1);
          m_n5 += int'(a5);
          m_n1 += int'(a1);
          m_quiet = (a5 || a1) ? 0 : m_quiet + 1;
          if (cn || m_quiet == TO) begin
            e.rv = 1'b1; e.r5 = 2'(m_n5); e.r1 = 2'(m_n1);
            m_n5 = 0; m_n1 = 0; m_quiet = 0; m_phase = P_IDLE;
          end else if (selv && sel != 2'b00) begin
            m_item = int'(sel); m_phase = P_OFFER;
          end
        end
        P_OFFER: begin
          e.rej = c5 || c1;
          if (st == 2'b01) begin
            m_n5 = 0; m_n1 = 0; m_item = 0; m_phase = P_WAIT;
          end
        end
        default: begin
          e.rej = c5 || c1;
          if (st == 2'b00) begin
            e.done = 1'b1; m_phase = P_IDLE;
          end
        end
      endcase
    end
    if (m_phase == P_OFFER) begin
      e.o5 = 2'(m_n5); e.o1 = 2'(m_n1); e.oit = 2'(m_item);
    end
    e.credit = 5'(5 * m_n5 + m_n1);
    e.busy   = (m_phase == P_OFFER) || (m_phase == P_WAIT);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [1:0] st);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, st, 1'b1);
  endtask

  // Monitor: pops one expectation per clock once the stimulus has queued it.
  initial begin
    snap_t a, e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = '{bus_if.coinInNTD_5, bus_if.coinInNTD_1, bus_if.itemTypeIn, bus_if.credit_value,
              bus_if.reject_coin, bus_if.refund_valid, bus_if.refund5, bus_if.refund1,
              bus_if.busy, bus_if.done};
        n_checks++;
        if (a === e) n_pass++;
        else
          $display("FAIL cycle %0d outputs: got o5=%0d o1=%0d it=%0d cr=%0d rej=%0b rv=%0b r5=%0d r1=%0d busy=%0b done=%0b | required o5=%0d o1=%0d it=%0d cr=%0d rej=%0b rv=%0b r5=%0d r1=%0d busy=%0b done=%0b",
                   cyc_no, a.o5, a.o1, a.oit, a.credit, a.rej, a.rv, a.r5, a.r1, a.busy, a.done,
                   e.o5, e.o1, e.oit, e.credit, e.rej, e.rv, e.r5, e.r1, e.busy, e.done);
      end
    end
  end

  initial begin
    int pct;
    reset = 1'b0;
    bus_if.coin5_pulse = 1'b0; bus_if.coin1_pulse = 1'b0;
    bus_if.item_sel = 2'b00; bus_if.item_sel_valid = 1'b0;
    bus_if.cancel = 1'b0; bus_if.service_type = 2'b00;

    cyc(0, 0, 2'b00, 0, 0, 2'b00, 0);
    cyc(0, 0, 2'b00, 0, 0, 2'b00, 0);
    idle(2, 2'b00);

    // 1: one NTD_5, two NTD_1, select A, core ON next cycle, then OFF.
    cyc(1, 0, 2'b00, 0, 0, 2'b00, 1);
    cyc(0, 1, 2'b00, 0, 0, 2'b00, 1);
    cyc(0, 1, 2'b00, 0, 0, 2'b00, 1);
    cyc(0, 0, 2'b01, 1, 0, 2'b00, 1);
    cyc(0, 0, 2'b00, 0, 0, 2'b01, 1);
    idle(2, 2'b10);
    idle(3, 2'b00);

    // 2: four NTD_5 saturates at 3 with one reject, then cancel.
    for (int i = 0; i < 4; i++) cyc(1, 0, 2'b00, 0, 0, 2'b00, 1);
    idle(1, 2'b00);
    cyc(0, 0, 2'b00, 0, 1, 2'b00, 1);
    idle(2, 2'b00);

    // 3: both coins with the selection, core BUSY for 5 cycles.
    cyc(1, 1, 2'b10, 1, 0, 2'b00, 1);
    idle(5, 2'b10);
    idle(1, 2'b01);
    idle(2, 2'b00);

    // 4: single NTD_1 then silence until the inactivity refund.
    cyc(0, 1, 2'b00, 0, 0, 2'b00, 1);
    idle(TO + 3, 2'b00);

    // 5: coin during WAIT_DONE rejected; select NONE ignored in COLLECT.
    cyc(1, 0, 2'b00, 0, 0, 2'b00, 1);
    cyc(0, 0, 2'b11, 1, 0, 2'b00, 1);
    cyc(0, 0, 2'b00, 0, 0, 2'b01, 1);
    cyc(1, 1, 2'b00, 0, 0, 2'b10, 1);
    idle(1, 2'b10);
    idle(2, 2'b00);
    cyc(0, 1, 2'b00, 0, 0, 2'b00, 1);
    cyc(0, 0, 2'b00, 1, 0, 2'b00, 1);
    idle(2, 2'b00);
    cyc(0, 0, 2'b00, 0, 1, 2'b00, 1);
    idle(1, 2'b00);

    // 6: reset while presenting a request.
    cyc(1, 0, 2'b00, 0, 0, 2'b00, 1);
    cyc(0, 0, 2'b11, 1, 0, 2'b10, 1);
    idle(1, 2'b10);
    cyc(0, 0, 2'b00, 0, 0, 2'b10, 0);
    idle(3, 2'b00);

    // Random traffic in blocks of varying activity so timeouts also occur.
    for (int b = 0; b < 60; b++) begin
      case ($urandom_range(0, 2))
        0:       pct = 2;
        1:       pct = 15;
        default: pct = 35;
      endcase
      for (int i = 0; i < 50; i++) begin
        logic [1:0] st;
        st = 2'($urandom_range(0, 3));
        if (st == 2'b11) st = 2'b10;
        cyc($urandom_range(0, 99) < pct, $urandom_range(0, 99) < pct,
            2'($urandom_range(0, 3)), $urandom_range(0, 99) < pct / 2,
            $urandom_range(0, 199) < 2, st, $urandom_range(0, 499) != 0);
      end
    end

    idle(3, 2'b00);
    @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
